spi_cmd_serializer: RTL and testbench

//  SPI mode-0 master transmitter for the control-group command frame: {opcode, key_addr, text_addr}, MSB first.

---
 rtl/spi_cmd_serializer_pkg.sv | 15 +
 rtl/spi_tx_tick.sv | 25 ++
 rtl/spi_cmd_serializer.sv | 131 +++++++++++++
 tb/tb_spi_cmd_serializer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_serializer_pkg.sv
// control_spi_pkg: shared types and sizing helpers for the control-group SPI command serializer.
package control_spi_pkg;
  localparam int CLK_DIV_MIN = 3;
  localparam int GAP_CYC_MIN = 3;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  function automatic int frame_w(input int opw, input int aw);
    return opw + 2 * aw;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_tx_tick.sv
// spi_tx_tick: loadable down-counter that raises a one-cycle tick n clk cycles after load.
module spi_tx_tick #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] n,
  output logic         tick
);
  logic [W-1:0] r_cnt;
  logic         r_run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (load) begin
      r_cnt <= n - W'(1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else r_cnt <= r_cnt - W'(1);
    end
  assign tick = r_run && r_cnt == '0;
endmodule

// File: rtl/spi_cmd_serializer.sv
// spi_cmd_serializer: SPI mode-0 master sending {opcode,key_addr,text_addr} MSB first.
// Optional abort support is enabled by defining SPI_TX_ABORT_EN.
module spi_cmd_serializer
  import control_spi_pkg::*;
#(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [OPCODEW-1:0] opcode,
  input  logic [ADDRW-1:0]   key_addr,
  input  logic [ADDRW-1:0]   text_addr,
  output logic               spi_clk,
  output logic               cs_n,
  output logic               mosi,
  output logic               busy,
`ifdef SPI_TX_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               done
);
  localparam int FRAME_W = frame_w(OPCODEW, ADDRW);
  localparam int DIV     = CLK_DIV < CLK_DIV_MIN ? CLK_DIV_MIN : CLK_DIV;
  localparam int GAPC    = GAP_CYC < GAP_CYC_MIN ? GAP_CYC_MIN : GAP_CYC;
  localparam int CNT_W   = clog2((DIV > GAPC ? DIV : GAPC) + 1);
  localparam int BIT_W   = clog2(FRAME_W);
  state_t             r_state;
  logic [FRAME_W-1:0] r_sh;
  logic [BIT_W-1:0]   r_bit;
  logic               w_tick, w_abort, w_load, w_last;
  logic [CNT_W-1:0]   w_n;
`ifdef SPI_TX_ABORT_EN
  logic               r_abt;
  assign w_abort = abort && (r_state == SETUP || r_state == SHIFT || r_state == HOLD);
`else
  assign w_abort = 1'b0;
`endif
  // One timer serves every phase; the gap length is loaded when entering GAP.
  assign w_load = (r_state == IDLE && valid_in) || w_abort || (w_tick && r_state != GAP);
  assign w_n    = (w_abort || r_state == HOLD) ? CNT_W'(GAPC) : CNT_W'(DIV);
  assign w_last = r_bit == BIT_W'(FRAME_W - 1);
  spi_tx_tick #(.W(CNT_W)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .load (w_load),
    .n    (w_n),
    .tick (w_tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sh      <= '0;
      r_bit     <= '0;
      spi_clk   <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      ready_out <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SPI_TX_ABORT_EN
      r_abt     <= 1'b0;
      aborted   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SPI_TX_ABORT_EN
      aborted <= 1'b0;
      if (w_abort) begin
        r_state <= GAP;
        spi_clk <= 1'b0;
        cs_n    <= 1'b1;
        mosi    <= 1'b0;
        r_abt   <= 1'b1;
      end else
`endif
      case (r_state)
        IDLE: if (valid_in) begin
          r_state   <= SETUP;
          r_sh      <= {opcode, key_addr, text_addr};
          r_bit     <= '0;
          spi_clk   <= 1'b0;
          cs_n      <= 1'b0;
          mosi      <= opcode[OPCODEW-1];
          busy      <= 1'b1;
          ready_out <= 1'b0;
        end
        SETUP: if (w_tick) begin
          r_state <= SHIFT;
          spi_clk <= 1'b1;
        end
        // The falling edge after the last bit keeps mosi; its low phase still belongs to SHIFT.
        SHIFT: if (w_tick) begin
          if (spi_clk) begin
            spi_clk <= 1'b0;
            if (!w_last) begin
              r_sh <= r_sh << 1;
              mosi <= r_sh[FRAME_W-2];
            end
          end else if (w_last) r_state <= HOLD;
          else begin
            spi_clk <= 1'b1;
            r_bit   <= r_bit + BIT_W'(1);
          end
        end
        HOLD: if (w_tick) begin
          r_state <= GAP;
          cs_n    <= 1'b1;
          mosi    <= 1'b0;
        end
        GAP: if (w_tick) begin
          r_state   <= IDLE;
          busy      <= 1'b0;
          ready_out <= 1'b1;
`ifdef SPI_TX_ABORT_EN
          done      <= !r_abt;
          aborted   <= r_abt;
          r_abt     <= 1'b0;
`else
          done      <= 1'b1;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_cmd_serializer.sv
// tb_spi_cmd_serializer: directed bench with an SPI slave monitor decoding frames from mosi.
module tb_spi_cmd_serializer;
  logic       clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0;
  logic [1:0] opcode = '0;
  logic [7:0] key_addr = '0, text_addr = '0;
  logic       ready_out, spi_clk, cs_n, mosi, busy, done;
`ifdef SPI_TX_ABORT_EN
  logic       abort = 1'b0, aborted;
`endif
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  spi_cmd_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .opcode   (opcode),
    .key_addr (key_addr),
    .text_addr(text_addr),
    .spi_clk  (spi_clk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .busy     (busy),
`ifdef SPI_TX_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .done     (done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic        p_clk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  logic [17:0] rx_word = '0, rx_last = '0;
  int nrise = 0, run = 0, bad_phase = 0, bad_mosi = 0, cs_low = 0, cs_high = 0;
  int last_gap = 0, last_low = 0, rx_cnt = 0, partial = 0;
  // Slave model: shift mosi on spi_clk rise while cs_n low; a frame is valid only with 18 bits.
  always @(negedge clk) begin
    if (!cs_n) begin
      if (p_cs) begin
        nrise = 0; rx_word = '0; run = 1; cs_low = 1; last_gap = cs_high;
      end else begin
        cs_low++;
        if (spi_clk != p_clk) begin
          if (run != 4) bad_phase++;
          run = 1;
        end else run++;
        if (spi_clk && !p_clk) begin
          nrise++;
          rx_word = {rx_word[16:0], mosi};
        end
        if (mosi != p_mosi && spi_clk) bad_mosi++;
      end
    end else if (!p_cs) begin
      last_low = cs_low;
      cs_high = 1;
      if (nrise == 18) begin
        rx_last = rx_word;
        rx_cnt++;
      end else partial++;
    end else cs_high++;
    p_clk = spi_clk; p_cs = cs_n; p_mosi = mosi;
  end
  task automatic send(input logic [1:0] op, input logic [7:0] k, input logic [7:0] t);
    @(negedge clk);
    opcode = op; key_addr = k; text_addr = t; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int rdy_bad);
    lat = 0; rdy_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (done) return;
      if (ready_out) rdy_bad++;
    end
    check("done_timeout", 0, 1);
  endtask
  task automatic wait_rise(input int n);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (nrise >= n) return;
    end
    check("rise_timeout", 0, 1);
  endtask
  initial begin
    #1ms;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int lat, rb, p0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_spi_clk", spi_clk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ready", ready_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef SPI_TX_ABORT_EN
    check("rst_aborted", aborted, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // single frame timing and content
    bad_phase = 0; bad_mosi = 0;
    send(2'b10, 8'hA5, 8'h3C);
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", ready_out, 0);
    wait_done(lat, rb);
    check("latency", lat, 157);
    check("ready_low_while_busy", rb, 0);
    check("ready_on_done", ready_out, 1);
    check("busy_on_done", busy, 0);
    check("frame_a53c", rx_last, 18'h2A53C);
    check("rx_cnt1", rx_cnt, 1);
    check("rise_edges", nrise, 18);
    check("cs_low_cycles", last_low, 152);
    check("phase_len", bad_phase, 0);
    check("mosi_stable_high", bad_mosi, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    // back-to-back with valid held high
    @(negedge clk);
    opcode = 2'b01; key_addr = 8'h01; text_addr = 8'hFF; valid_in = 1'b1;
    @(posedge clk);
    #1 opcode = 2'b11; key_addr = 8'h80; text_addr = 8'h00;
    wait_done(lat, rb);
    check("b2b_lat1", lat, 157);
    check("b2b_ready_on_done", ready_out, 1);
    check("b2b_frame1", rx_last, 18'h101FF);
    @(posedge clk);
    #1 valid_in = 1'b0;
    check("b2b_accept_on_done", busy, 1);
    wait_done(lat, rb);
    check("b2b_lat2", lat, 157);
    check("b2b_frame2", rx_last, 18'h38000);
    check("b2b_rx_cnt", rx_cnt, 3);
    check("b2b_gap_ge4", last_gap >= 4, 1);
    // input stability: fields churn and valid pulses mid-frame
    bad_phase = 0; bad_mosi = 0;
    send(2'b01, 8'h5A, 8'hC3);
    lat = 0; rb = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (ready_out) rb++;
      valid_in = i > 10 && i < 140 && i % 20 < 3;
      opcode = i[1:0]; key_addr = i[7:0]; text_addr = ~i[7:0];
    end
    valid_in = 1'b0;
    check("stab_latency", lat, 157);
    check("stab_ready_low", rb, 0);
    check("stab_frame", rx_last, 18'h15AC3);
    check("stab_phase", bad_phase, 0);
    check("stab_mosi", bad_mosi, 0);
    repeat (5) @(negedge clk);
    check("stab_no_extra_accept", busy, 0);
    check("stab_rx_cnt", rx_cnt, 4);
    // asynchronous reset at bit 9
    p0 = partial;
    send(2'b11, 8'h3C, 8'hA5);
    wait_rise(9);
    rst_n = 1'b0;
    #1;
    check("rstmid_cs_n", cs_n, 1);
    check("rstmid_spi_clk", spi_clk, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", ready_out, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rstmid_no_frame", rx_cnt, 4);
    check("rstmid_partial", partial - p0, 1);
    send(2'b11, 8'hC3, 8'h5A);
    wait_done(lat, rb);
    check("post_rst_latency", lat, 157);
    check("post_rst_frame", rx_last, 18'h3C35A);
    check("post_rst_rx_cnt", rx_cnt, 5);
`ifdef SPI_TX_ABORT_EN
    begin
      int sa, sd;
      sa = 0; sd = 0;
      send(2'b10, 8'h11, 8'h22);
      wait_rise(7);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_cs_n", cs_n, 1);
      check("abort_spi_clk", spi_clk, 0);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (aborted) sa++;
        if (done) sd++;
      end
      check("abort_pulse", sa, 1);
      check("abort_no_done", sd, 0);
      check("abort_no_frame", rx_cnt, 5);
      send(2'b01, 8'h33, 8'h44);
      wait_done(lat, rb);
      check("post_abort_frame", rx_last, 18'h13344);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
